// File: rtl/exe_muldiv_unit.sv
// Multi-cycle multiply/divide unit with valid/ready handshake on both sides.
// Optional macro MULDIV_EARLY_OUT_EN: single-cycle DIV for |a|<|b| and MUL with a zero operand.
module exe_muldiv_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             in_op_i,
   input  logic             in_signed_i,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_lo_o,
   output logic [WIDTH-1:0] out_hi_o,
   output logic             out_divzero_o,
   output logic             busy_o
);

   // state | meaning
   // IDLE  | waiting for a request, in_ready high
   // MUL   | multiply latency countdown
   // DIV   | restoring divide, one quotient bit per cycle
   // DONE  | result held until out_ready or flush
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int CNT_W = $clog2(WIDTH + MUL_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sg_q, sg_d, a_neg_q, a_neg_d, b_neg_q, b_neg_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
   logic             divzero_q, divzero_d;

   logic             idle, accept;
   logic             in_a_neg, in_b_neg;
   logic [WIDTH-1:0] in_a_mag, in_b_mag;

   assign idle     = (state_q == ST_IDLE);
   assign accept   = in_valid_i && idle && !flush_i;
   assign in_a_neg = in_signed_i & in_a_i[WIDTH-1];
   assign in_b_neg = in_signed_i & in_b_i[WIDTH-1];
   assign in_a_mag = in_a_neg ? -in_a_i : in_a_i;
   assign in_b_mag = in_b_neg ? -in_b_i : in_b_i;

   // Operands come straight from the inputs in IDLE so MUL_LAT==1 can finish at accept.
   logic [WIDTH-1:0]   mul_a, mul_b;
   logic               mul_sg;
   logic [2*WIDTH-1:0] mul_ext_a, mul_ext_b, product;

   assign mul_a     = idle ? in_a_i : a_q;
   assign mul_b     = idle ? in_b_i : b_q;
   assign mul_sg    = idle ? in_signed_i : sg_q;
   assign mul_ext_a = {{WIDTH{mul_sg & mul_a[WIDTH-1]}}, mul_a};
   assign mul_ext_b = {{WIDTH{mul_sg & mul_b[WIDTH-1]}}, mul_b};
   assign product   = mul_ext_a * mul_ext_b;

   // The accept edge performs the first divide iteration, DIV performs the remaining WIDTH-1.
   logic [WIDTH-1:0] st_rem, st_quo, st_dvs, step_rem, step_quo, q_fix, r_fix;
   logic [WIDTH:0]   shifted, diff;
   logic             step_ge;

   assign st_rem   = idle ? '0 : rem_q;
   assign st_quo   = idle ? in_a_mag : quo_q;
   assign st_dvs   = idle ? in_b_mag : dvs_q;
   assign shifted  = {st_rem, st_quo[WIDTH-1]};
   assign diff     = shifted - {1'b0, st_dvs};
   assign step_ge  = !diff[WIDTH];
   assign step_rem = step_ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign step_quo = {st_quo[WIDTH-2:0], step_ge};
   assign q_fix    = (a_neg_q ^ b_neg_q) ? -step_quo : step_quo;
   assign r_fix    = a_neg_q ? -step_rem : step_rem;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      sg_d      = sg_q;
      a_neg_d   = a_neg_q;
      b_neg_d   = b_neg_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      divzero_d = divzero_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d       = in_a_i;
               b_d       = in_b_i;
               sg_d      = in_signed_i;
               a_neg_d   = in_a_neg;
               b_neg_d   = in_b_neg;
               divzero_d = 1'b0;
               if (in_op_i) begin
                  if (in_b_i == '0) begin
                     state_d   = ST_DONE;
                     lo_d      = '1;
                     hi_d      = in_a_i;
                     divzero_d = 1'b1;
                  end
`ifdef MULDIV_EARLY_OUT_EN
                  else if (in_a_mag < in_b_mag) begin
                     state_d = ST_DONE;
                     lo_d    = '0;
                     hi_d    = in_a_i;
                  end
`endif
                  else begin
                     state_d = ST_DIV;
                     cnt_d   = DIV_CNT;
                     rem_d   = step_rem;
                     quo_d   = step_quo;
                     dvs_d   = in_b_mag;
                  end
               end else begin
`ifdef MULDIV_EARLY_OUT_EN
                  if (in_a_i == '0 || in_b_i == '0) begin
                     state_d = ST_DONE;
                     lo_d    = '0;
                     hi_d    = '0;
                  end else
`endif
                  if (MUL_LAT == 1) begin
                     state_d = ST_DONE;
                     lo_d    = product[WIDTH-1:0];
                     hi_d    = product[2*WIDTH-1:WIDTH];
                  end else begin
                     state_d = ST_MUL;
                     cnt_d   = MUL_CNT;
                  end
               end
            end
         end
         ST_MUL: begin
            if (cnt_q <= CNT_ONE) begin
               state_d = ST_DONE;
               lo_d    = product[WIDTH-1:0];
               hi_d    = product[2*WIDTH-1:WIDTH];
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_DIV: begin
            rem_d = step_rem;
            quo_d = step_quo;
            if (cnt_q <= CNT_ONE) begin
               state_d = ST_DONE;
               lo_d    = q_fix;
               hi_d    = r_fix;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            if (out_ready_i) state_d = ST_IDLE;
         end
      endcase
      if (flush_i) begin
         state_d   = ST_IDLE;
         divzero_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sg_q      <= 1'b0;
         a_neg_q   <= 1'b0;
         b_neg_q   <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sg_q      <= sg_d;
         a_neg_q   <= a_neg_d;
         b_neg_q   <= b_neg_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         divzero_q <= divzero_d;
      end
   end

   assign in_ready_o    = (state_q == ST_IDLE);
   assign out_valid_o   = (state_q == ST_DONE);
   assign busy_o        = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign out_lo_o      = lo_q;
   assign out_hi_o      = hi_q;
   assign out_divzero_o = divzero_q;

endmodule
